// File: rtl/cpu_ctrl.sv
// Instruction decoder and control FSM for the 16-bit register/ALU datapath.
// Latches one instruction per start handshake and sequences datapath strobes until it returns to WAIT.
module cpu_ctrl #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s,
    input  logic [15:0]   instr,
    output logic          w,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [3:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic [DW-1:0] sximm5,
    output logic [DW-1:0] sximm8,
    output logic          illegal
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GETA, S_GETB, S_ALU, S_WREG, S_WIMM
    } state_t;

    state_t      r_state, w_nxt;
    logic [15:0] r_ir;

    logic [2:0] w_opc, w_rn, w_rd, w_rm;
    logic [1:0] w_op, w_sh;
    logic       w_is_alu, w_mov_imm, w_mov_reg, w_mvn, w_cmp;

    assign w_opc = r_ir[15:13];
    assign w_op  = r_ir[12:11];
    assign w_rn  = r_ir[10:8];
    assign w_rd  = r_ir[7:5];
    assign w_sh  = r_ir[4:3];
    assign w_rm  = r_ir[2:0];

    assign w_is_alu  = (w_opc == 3'b101);
    assign w_mov_imm = (w_opc == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opc == 3'b110) && (w_op == 2'b00);
    assign w_mvn     = w_is_alu && (w_op == 2'b11);
    assign w_cmp     = w_is_alu && (w_op == 2'b01);

    assign sximm5 = {{(DW-5){r_ir[4]}}, r_ir[4:0]};
    assign sximm8 = {{(DW-8){r_ir[7]}}, r_ir[7:0]};

    // IR only loads on an accepted start, so it stays stable for the whole instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_WAIT && s)
                r_ir <= instr;
        end
    end

    always_comb begin
        w_nxt    = r_state;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 4'b0001;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        loadc    = 1'b0;
        loads    = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) w_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_mov_imm)                w_nxt = S_WIMM;
                else if (w_mov_reg || w_mvn)  w_nxt = S_GETB;
                else if (w_is_alu)            w_nxt = S_GETA;
                else begin
                    illegal = 1'b1;
                    w_nxt   = S_WAIT;
                end
            end
            S_GETA: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_nxt   = S_GETB;
            end
            S_GETB: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_nxt   = S_ALU;
            end
            S_ALU: begin
                shift = w_sh;
                // MOV reg reuses the adder with A forced to zero.
                ALUop = w_mov_reg ? 2'b00 : w_op;
                asel  = w_mov_reg;
                if (w_cmp) begin
                    loads = 1'b1;
                    w_nxt = S_WAIT;
                end else begin
                    loadc = 1'b1;
                    w_nxt = S_WREG;
                end
            end
            S_WREG: begin
                writenum = w_rd;
                vsel     = 4'b0001;
                write    = 1'b1;
                w_nxt    = S_WAIT;
            end
            S_WIMM: begin
                writenum = w_rn;
                vsel     = 4'b0100;
                write    = 1'b1;
                w_nxt    = S_WAIT;
            end
            default: w_nxt = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: per-cycle expected control vectors for each instruction class.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s;
    logic [15:0] instr;
    logic        w, write, loada, loadb, asel, bsel, loadc, loads, illegal;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm5, sximm8;

    int nchecks = 0;
    int nerrs   = 0;

    cpu_ctrl #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .instr(instr), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .sximm5(sximm5), .sximm8(sximm8), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Bundle: {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, illegal}
    function automatic logic [22:0] mk(input logic wv, input logic [2:0] rn, input logic [2:0] wn,
                                       input logic wr, input logic [3:0] vs, input logic la,
                                       input logic lb, input logic as, input logic bs,
                                       input logic [1:0] sh, input logic [1:0] op,
                                       input logic lc, input logic ls, input logic il);
        return {wv, rn, wn, wr, vs, la, lb, as, bs, sh, op, lc, ls, il};
    endfunction

    logic [22:0] IDLE, BUSY;
    assign IDLE = mk(1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    assign BUSY = mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    task automatic chk(input string tag, input logic [22:0] exp);
        logic [22:0] obs;
        obs = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, illegal};
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with s=1 and let the WAIT-state edge accept it.
    task automatic start(input logic [15:0] ins);
        instr = ins;
        s     = 1'b1;
        tick();
        s     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s     = 1'b0;
        instr = 16'h0000;
        #3;
        chk("reset_ctl", IDLE);
        chk16("reset_sximm8", sximm8, 16'h0000);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("idle_after_reset", IDLE);

        // MOV R0,#7
        start(16'hD007);
        chk("movi7_decode", BUSY);
        chk16("movi7_sximm8", sximm8, 16'h0007);
        chk16("movi7_sximm5", sximm5, 16'h0007);
        tick(); chk("movi7_wimm", mk(0, 0, 0, 1, 4'b0100, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("movi7_done", IDLE);

        // MOV R1,#-2
        start(16'hD1FE);
        chk("movim2_decode", BUSY);
        chk16("movim2_sximm8", sximm8, 16'hFFFE);
        chk16("movim2_sximm5", sximm5, 16'hFFFE);
        tick(); chk("movim2_wimm", mk(0, 0, 1, 1, 4'b0100, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("movim2_done", IDLE);

        // ADD R2,R1,R0,LSL#1 with s/instr wiggled while busy
        start(16'hA148);
        chk("add_decode", BUSY);
        instr = 16'hE000; s = 1'b1;
        tick(); chk("add_geta", mk(0, 1, 0, 0, 4'b0001, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        s = 1'b0;
        tick(); chk("add_getb", mk(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        s = 1'b1;
        tick(); chk("add_alu", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0));
        s = 1'b0;
        tick(); chk("add_wreg", mk(0, 0, 2, 1, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        chk16("add_ir_stable", sximm8, 16'h0048);
        tick(); chk("add_done", IDLE);

        // CMP R3,R4
        start(16'hAB04);
        chk("cmp_decode", BUSY);
        tick(); chk("cmp_geta", mk(0, 3, 0, 0, 4'b0001, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("cmp_getb", mk(0, 4, 0, 0, 4'b0001, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("cmp_alu", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 0));
        tick(); chk("cmp_done", IDLE);

        // MVN R6,R6,LSR#1
        start(16'hB8D6);
        chk("mvn_decode", BUSY);
        tick(); chk("mvn_getb", mk(0, 6, 0, 0, 4'b0001, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("mvn_alu", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b10, 2'b11, 1, 0, 0));
        tick(); chk("mvn_wreg", mk(0, 0, 6, 1, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("mvn_done", IDLE);

        // MOV R7,R3
        start(16'hC0E3);
        chk("movr_decode", BUSY);
        tick(); chk("movr_getb", mk(0, 3, 0, 0, 4'b0001, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("movr_alu", mk(0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0));
        tick(); chk("movr_wreg", mk(0, 0, 7, 1, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("movr_done", IDLE);

        // AND R5,R2,R1
        start(16'hB2A1);
        tick(); chk("and_geta", mk(0, 2, 0, 0, 4'b0001, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("and_getb", mk(0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("and_alu", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        tick(); chk("and_wreg", mk(0, 0, 5, 1, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tick(); chk("and_done", IDLE);

        // Illegal E000, then 110/01 held back-to-back on s
        instr = 16'hE000; s = 1'b1;
        tick(); chk("ill_e000_decode", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1));
        instr = 16'hC800;
        tick(); chk("ill_e000_done", IDLE);
        tick(); chk("ill_c800_decode", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1));
        s = 1'b0;
        tick(); chk("ill_c800_done", IDLE);

        // Reset asserted in the ALU state of an ADD
        start(16'hA148);
        tick(); tick(); tick();
        chk("rst_pre_alu", mk(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0));
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", IDLE);
        chk16("rst_async_sximm8", sximm8, 16'h0000);
        tick();
        #2 rst_n = 1'b1;
        tick(); chk("rst_release_1", IDLE);
        tick(); chk("rst_release_2", IDLE);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
